// File: rtl/str_arb.sv
// str_arb: merges N valid/ready streams into one, round-robin with bursts of up to MAXB beats per owner.
// Registered output, 1-cycle latency at 1 beat/cycle; s_tready is combinational from m_tready/s_tvalid and drops while the output stalls.
module str_arb #(
  parameter int N    = 4,
  parameter int VW   = 32,
  parameter int MAXB = 4,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_tvalid,
  output logic [N-1:0]    s_tready,
  input  logic [N*VW-1:0] s_tvalue,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [VW-1:0]   m_tvalue,
  output logic [IW-1:0]   m_tid
);

  localparam int CW = $clog2(MAXB + 1);

  logic            m_tvalid_q, m_tvalid_d;
  logic [VW-1:0]   m_tvalue_q, m_tvalue_d;
  logic [IW-1:0]   m_tid_q, m_tid_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            owned_q, owned_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ld;
  logic            keep;
  logic            sel_vld;
  logic [IW-1:0]   sel_idx;

  // owner + off, wrapped into 0..N-1; off never exceeds N so one subtraction suffices
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign ld = ~m_tvalid_q | m_tready;

  always_comb begin
    keep    = owned_q && s_tvalid[owner_q] && (cnt_q < CW'(MAXB));
    sel_vld = 1'b0;
    sel_idx = owner_q;
    if (keep) begin
      sel_vld = 1'b1;
    end else begin
      // owner is visited last, so a saturated owner only wins when nobody else is asking
      for (int i = 1; i <= N; i++) begin
        if (!sel_vld && s_tvalid[wrap_add(owner_q, i)]) begin
          sel_vld = 1'b1;
          sel_idx = wrap_add(owner_q, i);
        end
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (rst && ld && sel_vld) s_tready[sel_idx] = 1'b1;
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tvalue_d = m_tvalue_q;
    m_tid_d    = m_tid_q;
    owner_d    = owner_q;
    owned_d    = owned_q;
    cnt_d      = cnt_q;
    if (ld) begin
      if (!s_tvalid[owner_q]) owned_d = 1'b0;
      if (sel_vld) begin
        m_tvalid_d = 1'b1;
        m_tvalue_d = s_tvalue[int'(sel_idx) * VW +: VW];
        m_tid_d    = sel_idx;
        if (owned_q && (sel_idx == owner_q)) begin
          cnt_d = (cnt_q < CW'(MAXB)) ? cnt_q + CW'(1) : CW'(1);
        end else begin
          owner_d = sel_idx;
          owned_d = 1'b1;
          cnt_d   = CW'(1);
        end
      end else begin
        m_tvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_tvalid_q <= 1'b0;
      m_tvalue_q <= '0;
      m_tid_q    <= '0;
      owner_q    <= IW'(N - 1);
      owned_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tvalue_q <= m_tvalue_d;
      m_tid_q    <= m_tid_d;
      owner_q    <= owner_d;
      owned_q    <= owned_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tvalue = m_tvalue_q;
  assign m_tid    = m_tid_q;

endmodule

// File: tb/tb_str_arb.sv
// tb_str_arb: three str_arb instances (MAXB = 1, 4, 2), one exercised at a time.
// Expected (id, value) beats are queued with the stimulus and popped on each output handshake.
module tb_str_arb;
  localparam int N  = 4;
  localparam int VW = 32;
  localparam int IW = 2;
  localparam int NG = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_tvalid [NG];
  logic [N-1:0]    s_tready [NG];
  logic [N*VW-1:0] s_tvalue [NG];
  logic            m_tvalid [NG];
  logic            m_tready [NG];
  logic [VW-1:0]   m_tvalue [NG];
  logic [IW-1:0]   m_tid    [NG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    str_arb #(.N(N), .VW(VW), .MAXB(g == 0 ? 1 : (g == 1 ? 4 : 2))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (s_tvalid[g]),
      .s_tready (s_tready[g]),
      .s_tvalue (s_tvalue[g]),
      .m_tvalid (m_tvalid[g]),
      .m_tready (m_tready[g]),
      .m_tvalue (m_tvalue[g]),
      .m_tid    (m_tid[g])
    );
  end

  int                 checks;
  int                 errors;
  int                 act;
  string              scn;
  int                 rem   [N];
  int                 seq   [N];
  int                 eseq  [N];
  int                 vbase [N];
  int                 vstep [N];
  logic [IW+VW-1:0]   exp_q [$];
  logic               stall_chk;
  logic [VW-1:0]      snap_v;
  logic [IW-1:0]      snap_id;
  logic [VW-1:0]      last_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=0x%0h want=0x%0h", scn, tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] val_of(input int i, input int s);
    return VW'(vbase[i] + s * vstep[i]);
  endfunction

  task automatic drive();
    for (int g = 0; g < NG; g++) begin
      s_tvalid[g] = '0;
      s_tvalue[g] = '0;
    end
    for (int i = 0; i < N; i++) begin
      s_tvalid[act][i] = (rem[i] > 0);
      s_tvalue[act][i*VW +: VW] = val_of(i, seq[i]);
    end
  endtask

  task automatic push(input int tid);
    exp_q.push_back({IW'(tid), val_of(tid, eseq[tid])});
    eseq[tid]++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int g = 0; g < NG; g++) begin
      s_tvalid[g] = '1;
      s_tvalue[g] = '1;
    end
    repeat (2) begin
      @(negedge clk);
      for (int g = 0; g < NG; g++) chk("rst_rdy", 64'(s_tready[g]), 64'(0));
      @(posedge clk);
      #1;
      for (int g = 0; g < NG; g++) begin
        chk("rst_vld", 64'(m_tvalid[g]), 64'(0));
        chk("rst_val", 64'(m_tvalue[g]), 64'(0));
        chk("rst_id",  64'(m_tid[g]),    64'(0));
      end
    end
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      rem[i]   = 0;
      seq[i]   = 0;
      eseq[i]  = 0;
      vbase[i] = (i + 1) * 32'h0101_0000;
      vstep[i] = 1;
    end
    for (int g = 0; g < NG; g++) begin
      s_tvalid[g] = '0;
      s_tvalue[g] = '0;
    end
    rst = 1'b1;
  endtask

  task automatic setup(input string name, input int g, input int r0, input int r1,
                       input int r2, input int r3);
    scn    = name;
    act    = g;
    rem[0] = r0;
    rem[1] = r1;
    rem[2] = r2;
    rem[3] = r3;
    drive();
  endtask

  task automatic cycle();
    logic [N-1:0]     f;
    logic             ofire;
    logic [VW-1:0]    ov;
    logic [IW-1:0]    oid;
    logic [VW-1:0]    fv;
    logic [IW+VW-1:0] e;
    int               fi;
    @(negedge clk);
    f = s_tvalid[act] & s_tready[act];
    chk("onehot", 64'($onehot0(s_tready[act])), 64'(1));
    if (stall_chk) begin
      chk("bp_rdy", 64'(s_tready[act]), 64'(0));
      chk("bp_vld", 64'(m_tvalid[act]), 64'(1));
      chk("bp_val", 64'(m_tvalue[act]), 64'(snap_v));
      chk("bp_id",  64'(m_tid[act]),    64'(snap_id));
    end
    ofire = m_tvalid[act] & m_tready[act];
    ov    = m_tvalue[act];
    oid   = m_tid[act];
    fi    = -1;
    fv    = '0;
    for (int i = 0; i < N; i++) begin
      if (f[i]) begin
        fi = i;
        fv = s_tvalue[act][i*VW +: VW];
      end
    end
    @(posedge clk);
    #1;
    if (ofire) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_id",  64'(oid), 64'(e[VW +: IW]));
        chk("out_val", 64'(ov),  64'(e[VW-1:0]));
        last_v = ov;
      end else begin
        chk("extra_beat", 64'(exp_q.size()), 64'(1));
      end
    end
    if (fi >= 0) begin
      chk("lat_vld", 64'(m_tvalid[act]), 64'(1));
      chk("lat_id",  64'(m_tid[act]),    64'(fi));
      chk("lat_val", 64'(m_tvalue[act]), 64'(fv));
      seq[fi]++;
      rem[fi]--;
    end
    drive();
  endtask

  // Drains the queue; beats on consecutive cycles give exactly exp_cyc cycles.
  task automatic run(input int exp_cyc);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    chk("drain",  64'(exp_q.size()), 64'(0));
    chk("cycles", 64'(n), 64'(exp_cyc));
    cycle();
    chk("idle_vld", 64'(m_tvalid[act]), 64'(0));
    chk("idle_val", 64'(m_tvalue[act]), 64'(last_v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    act       = 0;
    scn       = "reset";
    stall_chk = 1'b0;
    last_v    = '0;
    rst       = 1'b0;
    for (int g = 0; g < NG; g++) begin
      m_tready[g] = 1'b1;
      s_tvalid[g] = '0;
      s_tvalue[g] = '0;
    end
    do_reset();

    // lone requester 2 streaming 0x11, 0x22, 0x33
    vbase[2] = 32'h11;
    vstep[2] = 32'h11;
    setup("single", 1, 0, 0, 3, 0);
    repeat (3) push(2);
    run(4);

    // MAXB=1: pure round-robin 0,1,2,3,0,1
    do_reset();
    setup("rr", 0, 2, 2, 1, 1);
    push(0); push(1); push(2); push(3); push(0); push(1);
    run(7);

    // MAXB=4: bursts of four, saturated owner 0 yields to the others first
    do_reset();
    setup("burst", 1, 8, 4, 4, 4);
    for (int t = 0; t < 4; t++) repeat (4) push(t);
    repeat (4) push(0);
    run(21);

    // requester 0 drops after two beats, grant moves on without a bubble
    do_reset();
    setup("drop", 1, 2, 4, 1, 1);
    push(0); push(0); push(1); push(1); push(1); push(1); push(2); push(3);
    run(9);

    // five-cycle output stall with a beat held
    do_reset();
    setup("bp", 1, 3, 3, 0, 0);
    push(0); push(0); push(0); push(1); push(1); push(1);
    cycle();
    cycle();
    m_tready[1] = 1'b0;
    snap_v      = val_of(0, 1);
    snap_id     = '0;
    stall_chk   = 1'b1;
    repeat (5) cycle();
    stall_chk   = 1'b0;
    m_tready[1] = 1'b1;
    run(5);

    // MAXB=2, single requester re-granted past saturation
    do_reset();
    setup("sat", 2, 0, 5, 0, 0);
    repeat (5) push(1);
    run(6);

    // reset while a beat is stalled: beat dropped, search restarts at 0
    do_reset();
    setup("midrst", 1, 4, 4, 4, 4);
    push(0);
    cycle();
    cycle();
    m_tready[1] = 1'b0;
    cycle();
    do_reset();
    m_tready[1] = 1'b1;
    setup("midrst", 1, 1, 1, 1, 1);
    push(0); push(1); push(2); push(3);
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/str_arb.md
STR_ARB -- requirements
Module: str_arb

Interface
REQ-001 Parameter N, default 4, number of requester streams (N >= 2).
REQ-002 Parameter VW, default 32, value width.
REQ-003 Parameter MAXB, default 4, max consecutive beats granted to one requester (MAXB >= 1).
REQ-004 Derived IW = max(1, clog2(N)), requester index width.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 s_tvalid  input  N  per-requester valid, bit i = requester i.
REQ-008 s_tready  output  N  per-requester ready, bit i = requester i.
REQ-009 s_tvalue  input  N*VW  per-requester value, requester i at bits [i*VW +: VW].
REQ-010 m_tvalid  output  1  merged stream valid (registered).
REQ-011 m_tready  input  1  merged stream ready.
REQ-012 m_tvalue  output  VW  merged stream value (registered).
REQ-013 m_tid  output  IW  index of requester that sourced current m_tvalue (registered).

Function
REQ-014 Transfer on any stream SHALL occur on a rising clk edge where valid and ready are both 1.
REQ-015 Load enable ld SHALL be (~m_tvalid | m_tready), combinational.
REQ-016 Selection SHALL be: owner, if owned flag set, s_tvalid[owner]=1 and cnt < MAXB; otherwise first i with s_tvalid[i]=1 searching owner+1, owner+2, ... mod N (full wrap, including owner last).
REQ-017 s_tready[i] SHALL be 1 only when ld=1, a selection exists and selection = i; s_tready SHALL be zero or one-hot every cycle.
REQ-018 s_tready SHALL depend combinationally on m_tready and s_tvalid; no dependency of s_tvalid on s_tready is permitted upstream.
REQ-019 On an input transfer from requester k: m_tvalid<=1, m_tvalue<=s_tvalue[k], m_tid<=k (latency 1 cycle, throughput 1 beat/cycle).
REQ-020 When ld=1 and no selection exists: m_tvalid<=0; m_tvalue, m_tid hold.
REQ-021 When ld=0: m_tvalid, m_tvalue, m_tid SHALL hold (output stable while stalled).
REQ-022 Ownership: on transfer from k with k = owner and owned set, cnt<=cnt+1; otherwise owner<=k, owned<=1, cnt<=1.
REQ-023 cnt SHALL saturate at MAXB; when cnt = MAXB the owner is skipped for one arbitration if any other requester is valid; if no other is valid the owner SHALL be reselected with cnt<=1.
REQ-024 When ld=1 and s_tvalid[owner]=0, owned<=0; the next selection searches from owner+1.
REQ-025 MAXB=1 SHALL yield pure round-robin.
REQ-026 Selection not based on a stalled (ld=0) cycle SHALL NOT change owner, owned or cnt.

Reset
REQ-027 While rst=0 at a clk edge: m_tvalid<=0, m_tvalue<=0, m_tid<=0, owner<=N-1, owned<=0, cnt<=0.
REQ-028 s_tready SHALL be all-zero while rst=0 regardless of other inputs.
REQ-029 Reset asserted mid-operation SHALL discard any held output beat; first grant after release SHALL search from requester 0.

Verification
REQ-030 Single requester: N=4, only s_tvalid[2]=1, values 0x11,0x22,0x33, m_tready=1 -> m_tvalue 0x11,0x22,0x33 on consecutive cycles, m_tid=2, first output 1 cycle after first accept.
REQ-031 All valid, MAXB=1, m_tready=1 -> m_tid sequence 0,1,2,3,0,1 from reset.
REQ-032 All valid, MAXB=4 -> m_tid 0,0,0,0,1,1,1,1,2...; requester 0 drops valid after 2 beats -> grant moves to 1 on the next cycle.
REQ-033 Backpressure: m_tready=0 for 5 cycles with m_tvalid=1 -> m_tvalue, m_tid constant, s_tready=0 throughout; m_tready=1 -> streaming resumes with no beat lost or duplicated.
REQ-034 Only requester 1 valid, MAXB=2, 5 beats -> all 5 accepted back-to-back, m_tid=1 (saturation reselect).
REQ-035 rst=0 asserted while m_tvalid=1 and m_tready=0 -> next cycle m_tvalid=0, s_tready=0; after release with all valid first m_tid=0.
